cordic_phase: RTL



---
 rtl/cordic_phase.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/cordic_phase.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_phase
//  Description : Iterative vectoring-mode CORDIC. Converts one I/Q sample pair
//                into a signed phase angle (radians, 10 fractional bits,
//                saturated to +/-3217). A single shift/add datapath is reused
//                for ITER cycles per sample.
//  Ports       : clock   - system clock, rising edge
//                reset   - asynchronous, active-high; clears all state
//                sample  - input strobe, accepted while busy = 0
//                I, Q    - signed IN_W-bit in-phase / quadrature samples
//                phase   - signed 19-bit phase result, held between valids
//                valid   - one-cycle pulse when phase (and mag) update
//                busy    - high while a sample is being processed
//                overrun - one-cycle pulse for each sample seen while busy
//                mag     - unsigned magnitude incl. CORDIC gain
//  Option      : CORDIC_MAG_EN - when defined, mag is registered from the
//                final x value; when undefined, mag is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_phase #(
    parameter int ITER = 14,
    parameter int IN_W = 18
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   sample,
    input  logic signed [IN_W-1:0] I,
    input  logic signed [IN_W-1:0] Q,
    output logic signed [18:0]     phase,
    output logic                   valid,
    output logic                   busy,
    output logic                   overrun,
    output logic [IN_W+1:0]        mag
);

    // x/y carry three guard bits: one for negating the most negative input,
    // two for the ~1.647 CORDIC gain on a 45-degree vector.
    localparam int XW = IN_W + 3;
    localparam int ZW = 23;
    localparam int KW = 4;
    localparam logic signed [ZW-1:0] PI_Z   = 23'sd51472;
    localparam logic signed [ZW-1:0] PH_MAX = 23'sd3217;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_ITERATE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                 state;
    logic [KW-1:0]          k;
    logic signed [IN_W-1:0] in_i;
    logic signed [IN_W-1:0] in_q;
    logic                   in_zero;
    logic signed [XW-1:0]   x;
    logic signed [XW-1:0]   y;
    logic signed [ZW-1:0]   z;

    logic signed [XW-1:0]   i_ext;
    logic signed [XW-1:0]   q_ext;
    logic signed [XW-1:0]   x_sh;
    logic signed [XW-1:0]   y_sh;
    logic signed [ZW-1:0]   atan_k;
    logic signed [ZW-1:0]   z_rnd;
    logic signed [ZW-1:0]   z_div;
    logic signed [18:0]     phase_sat;

    // round(atan(2^-k) * 2^14)
    function automatic logic signed [ZW-1:0] atan_lut(input logic [KW-1:0] idx);
        logic signed [ZW-1:0] v;
        case (idx)
            4'd0:    v = 23'sd12868;
            4'd1:    v = 23'sd7596;
            4'd2:    v = 23'sd4014;
            4'd3:    v = 23'sd2037;
            4'd4:    v = 23'sd1023;
            4'd5:    v = 23'sd512;
            4'd6:    v = 23'sd256;
            4'd7:    v = 23'sd128;
            4'd8:    v = 23'sd64;
            4'd9:    v = 23'sd32;
            4'd10:   v = 23'sd16;
            4'd11:   v = 23'sd8;
            4'd12:   v = 23'sd4;
            4'd13:   v = 23'sd2;
            default: v = 23'sd1;
        endcase
        return v;
    endfunction

    always_comb begin
        i_ext  = {{3{in_i[IN_W-1]}}, in_i};
        q_ext  = {{3{in_q[IN_W-1]}}, in_q};
        x_sh   = x >>> k;
        y_sh   = y >>> k;
        atan_k = atan_lut(k);
        // z is in 2^-14 rad; phase is in 2^-10 rad, rounded half-up.
        z_rnd  = z + 23'sd8;
        z_div  = z_rnd >>> 4;
        if (z_div > PH_MAX) begin
            phase_sat = 19'sd3217;
        end else if (z_div < -PH_MAX) begin
            phase_sat = -19'sd3217;
        end else begin
            phase_sat = z_div[18:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            k       <= '0;
            in_i    <= '0;
            in_q    <= '0;
            in_zero <= 1'b0;
            x       <= '0;
            y       <= '0;
            z       <= '0;
            phase   <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            valid   <= 1'b0;
            // busy mirrors "state != IDLE", so this flags every strobe that
            // lands while a computation is in flight.
            overrun <= sample & busy;
            case (state)
                S_IDLE: begin
                    if (sample) begin
                        in_i  <= I;
                        in_q  <= Q;
                        busy  <= 1'b1;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    in_zero <= (in_i == '0) && (in_q == '0);
                    k       <= '0;
                    if (in_i[IN_W-1]) begin
                        // Rotate by 180 degrees into the right half-plane.
                        x <= -i_ext;
                        y <= -q_ext;
                        z <= in_q[IN_W-1] ? -PI_Z : PI_Z;
                    end else begin
                        x <= i_ext;
                        y <= q_ext;
                        z <= '0;
                    end
                    state <= S_ITERATE;
                end
                S_ITERATE: begin
                    if (!y[XW-1]) begin
                        x <= x + y_sh;
                        y <= y - x_sh;
                        z <= z + atan_k;
                    end else begin
                        x <= x - y_sh;
                        y <= y + x_sh;
                        z <= z - atan_k;
                    end
                    if (k == KW'(ITER - 1)) begin
                        k     <= '0;
                        state <= S_DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_DONE: begin
                    // Zero input would otherwise accumulate sum(ATAN).
                    phase <= in_zero ? 19'sd0 : phase_sat;
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CORDIC_MAG_EN
    // Final x is non-negative after right-half-plane pre-rotation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mag <= '0;
        end else if (state == S_DONE) begin
            mag <= x[IN_W+1:0];
        end
    end
`else
    assign mag = '0;
`endif

endmodule
`default_nettype wire
